fpu_issue_unit: RTL and testbench

- Valid/ready wrapper around the fixed-latency `FPU` pipeline. Sits directly upstream and downstream of it.
- Buffers incoming operand/operation requests and issues at most one per cycle into the FPU.
- Tracks in-flight operations with a valid shift register matched to the FPU depth, then captures `Result` into an output FIFO.
- Credit-limited issue: a result is never dropped, even though the FPU itself cannot stall.

---
 rtl/fpu_issue_unit.sv | 175 +++++++++++++++++
 tb/tb_fpu_issue_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_unit.sv
// Valid/ready issue wrapper around the fixed-latency FPU; define FPU_ISSUE_TAG_EN to carry request tags.
// Push-to-OutValid latency PIPE_DEPTH+1; issue waits on output-FIFO credits so no result is ever dropped.

module fpuIssueFifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           pushData,
  input  logic                   pop,
  output logic [W-1:0]           headData,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];
endmodule

module fpu_issue_unit #(
  parameter int PIPE_DEPTH = 7,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 8,
  parameter int TAG_W      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InOperand1,
  input  logic [31:0]      InOperand2,
  input  logic [1:0]       InOperation,
`ifdef FPU_ISSUE_TAG_EN
  input  logic [TAG_W-1:0] InTag,
`endif
  output logic [31:0]      FpuOperand1,
  output logic [31:0]      FpuOperand2,
  output logic [1:0]       FpuOperation,
  input  logic [31:0]      FpuResult,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      OutResult,
`ifdef FPU_ISSUE_TAG_EN
  output logic [TAG_W-1:0] OutTag,
`endif
  output logic             Busy
);
  localparam int INCW  = $clog2(IN_DEPTH) + 1;
  localparam int OUTCW = $clog2(OUT_DEPTH) + 1;
  localparam int IFW   = $clog2(PIPE_DEPTH + 1);
`ifdef FPU_ISSUE_TAG_EN
  localparam int TW = TAG_W;
`else
  localparam int TW = 0 * TAG_W;
`endif
  localparam int IN_W  = 66 + TW;
  localparam int OUT_W = 32 + TW;
  localparam logic [INCW-1:0] IN_FULL = INCW'(IN_DEPTH);
  localparam logic [IFW-1:0]  IF_ONE  = 1;

  logic [INCW-1:0]       inCount;
  logic [OUTCW-1:0]      outCount;
  logic [IFW-1:0]        inflight;
  logic [PIPE_DEPTH-1:0] vld;
  logic [IN_W-1:0]       inPushData;
  logic [IN_W-1:0]       inHead;
  logic [OUT_W-1:0]      outPushData;
  logic [OUT_W-1:0]      outHead;
  logic                  issue;
  logic                  capture;
  logic                  outPop;

  assign InReady  = (inCount != IN_FULL);
  // Credits count every result that will need an output slot; a same-cycle pop frees one only next cycle.
  assign issue    = (inCount != '0) && ((int'(inflight) + int'(outCount)) < OUT_DEPTH);
  assign capture  = vld[PIPE_DEPTH-1];
  assign OutValid = (outCount != '0);
  assign outPop   = OutValid && OutReady;
  assign Busy     = (inCount != '0) || (inflight != '0) || OutValid;

`ifdef FPU_ISSUE_TAG_EN
  assign inPushData = {InTag, InOperation, InOperand1, InOperand2};
`else
  assign inPushData = {InOperation, InOperand1, InOperand2};
`endif

  fpuIssueFifo #(.W(IN_W), .DEPTH(IN_DEPTH)) uInFifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (InValid && InReady),
    .pushData (inPushData),
    .pop      (issue),
    .headData (inHead),
    .count    (inCount)
  );

  // Operand registers hold on idle cycles; the FPU output for those slots is ignored via vld.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FpuOperand1  <= '0;
      FpuOperand2  <= '0;
      FpuOperation <= '0;
      vld          <= '0;
      inflight     <= '0;
    end else begin
      vld <= {vld[PIPE_DEPTH-2:0], issue};
      if (issue) {FpuOperation, FpuOperand1, FpuOperand2} <= inHead[65:0];
      case ({issue, capture})
        2'b10:   inflight <= inflight + IF_ONE;
        2'b01:   inflight <= inflight - IF_ONE;
        default: ;
      endcase
    end
  end

`ifdef FPU_ISSUE_TAG_EN
  logic [TAG_W-1:0] tagP [PIPE_DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PIPE_DEPTH; i++) tagP[i] <= '0;
    end else begin
      if (issue) tagP[0] <= inHead[IN_W-1 -: TAG_W];
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (vld[i-1]) tagP[i] <= tagP[i-1];
      end
    end
  end

  assign outPushData = {tagP[PIPE_DEPTH-1], FpuResult};
  assign OutTag      = outHead[OUT_W-1 -: TAG_W];
`else
  assign outPushData = FpuResult;
`endif

  fpuIssueFifo #(.W(OUT_W), .DEPTH(OUT_DEPTH)) uOutFifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (capture),
    .pushData (outPushData),
    .pop      (outPop),
    .headData (outHead),
    .count    (outCount)
  );

  assign OutResult = outHead[31:0];
endmodule

// File: tb/tb_fpu_issue_unit.sv
// Randomized and directed bench for fpu_issue_unit with a queue-level reference model and FPU stand-in.
module tb_fpu_issue_unit;
  localparam int PIPE_DEPTH = 7;
  localparam int IN_DEPTH   = 4;
  localparam int OUT_DEPTH  = 8;
  localparam int TAG_W      = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             InValid;
  logic             InReady;
  logic [31:0]      InOperand1;
  logic [31:0]      InOperand2;
  logic [1:0]       InOperation;
  logic [TAG_W-1:0] InTag;
  logic [31:0]      FpuOperand1;
  logic [31:0]      FpuOperand2;
  logic [1:0]       FpuOperation;
  logic [31:0]      FpuResult;
  logic             OutValid;
  logic             OutReady = 1'b1;
  logic [31:0]      OutResult;
`ifdef FPU_ISSUE_TAG_EN
  logic [TAG_W-1:0] OutTag;
`endif
  logic             Busy;

  int tests = 0;
  int fails = 0;
  int popCnt = 0;
  bit randReady = 0;
  bit fixedReady = 1;
  bit tagRec = 0;
  logic [TAG_W-1:0] tagLog [$];

  fpu_issue_unit #(.PIPE_DEPTH(PIPE_DEPTH), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .InValid      (InValid),
    .InReady      (InReady),
    .InOperand1   (InOperand1),
    .InOperand2   (InOperand2),
    .InOperation  (InOperation),
`ifdef FPU_ISSUE_TAG_EN
    .InTag        (InTag),
`endif
    .FpuOperand1  (FpuOperand1),
    .FpuOperand2  (FpuOperand2),
    .FpuOperation (FpuOperation),
    .FpuResult    (FpuResult),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .OutResult    (OutResult),
`ifdef FPU_ISSUE_TAG_EN
    .OutTag       (OutTag),
`endif
    .Busy         (Busy)
  );

  initial forever #5 CLK = ~CLK;

  // Float arithmetic for operands that are normal or zero; results truncate to single precision.
  function automatic real f2r(input logic [31:0] f);
    if (f[30:23] == 8'd0) return 0.0;
    return $bitstoreal({f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpuCalc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real x;
    real y;
    x = f2r(a);
    y = f2r(b);
    case (op)
      2'b00:   return r2f(x + y);
      2'b01:   return r2f(x - y);
      2'b10:   return r2f(x * y);
      default: return (y == 0.0) ? 32'd0 : r2f(x / y);
    endcase
  endfunction

  // FPU stand-in: PIPE_DEPTH-1 register stages, no reset, no stall.
  logic [31:0] fpuStage [PIPE_DEPTH-1];
  always @(posedge CLK) begin
    fpuStage[0] <= fpuCalc(FpuOperand1, FpuOperand2, FpuOperation);
    for (int i = 1; i < PIPE_DEPTH - 1; i++) fpuStage[i] <= fpuStage[i-1];
  end
  assign FpuResult = fpuStage[PIPE_DEPTH-2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: requests as queue entries moving input -> in flight -> output.
  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               due;
  } req_t;
  req_t inQ [$];
  req_t flQ [$];
  req_t outQ [$];
  int   mcyc = 0;

  initial forever begin
    bit   doPush, doIssue, doCap, doPop;
    req_t r;
    @(posedge CLK or posedge RST);
    if (RST) begin
      inQ.delete();
      flQ.delete();
      outQ.delete();
      mcyc = 0;
    end else begin
      doPush  = InValid && (inQ.size() < IN_DEPTH);
      doIssue = (inQ.size() > 0) && ((flQ.size() + outQ.size()) < OUT_DEPTH);
      doCap   = (flQ.size() > 0) && (flQ[0].due == mcyc);
      doPop   = (outQ.size() > 0) && OutReady;
      if (doPop) void'(outQ.pop_front());
      if (doCap) begin
        if (outQ.size() >= OUT_DEPTH) begin
          tests++;
          fails++;
          $display("FAIL overflow: output queue full at capture, %0t", $time);
        end
        outQ.push_back(flQ.pop_front());
      end
      if (doIssue) begin
        r = inQ.pop_front();
        r.due = mcyc + PIPE_DEPTH;
        flQ.push_back(r);
      end
      if (doPush) begin
        r.res = fpuCalc(InOperand1, InOperand2, InOperation);
        r.tag = InTag;
        r.due = 0;
        inQ.push_back(r);
      end
      mcyc++;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      check("rstInReady", InReady, 1);
      check("rstOutValid", OutValid, 0);
      check("rstBusy", Busy, 0);
    end else begin
      check("InReady", InReady, inQ.size() != IN_DEPTH);
      check("OutValid", OutValid, outQ.size() != 0);
      check("Busy", Busy, (inQ.size() + flQ.size() + outQ.size()) != 0);
      check("outCountBound", dut.outCount <= OUT_DEPTH, 1);
      if (outQ.size() != 0) begin
        check("OutResult", OutResult, outQ[0].res);
`ifdef FPU_ISSUE_TAG_EN
        check("OutTag", OutTag, outQ[0].tag);
`endif
      end
      if (OutValid && OutReady) begin
        popCnt++;
`ifdef FPU_ISSUE_TAG_EN
        if (tagRec) tagLog.push_back(OutTag);
`endif
      end
    end
  end

  initial forever begin
    @(posedge CLK);
    #2;
    OutReady = randReady ? 1'($urandom_range(0, 1)) : fixedReady;
  end

  logic [31:0] vals [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h3F000000, 32'h3FC00000, 32'hC0000000, 32'h41000000};

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic pushReq(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [TAG_W-1:0] tg);
    int n;
    InValid = 1'b1;
    InOperand1 = a;
    InOperand2 = b;
    InOperation = op;
    InTag = tg;
    n = 0;
    @(negedge CLK);
    while (!InReady && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!InReady) begin
      tests++;
      fails++;
      $display("FAIL pushTimeout: InReady stayed 0 required 1");
    end
    @(posedge CLK);
    #1;
    InValid = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    while (Busy && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(nm, Busy, 0);
  endtask

  task automatic singleOp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] exp, input string nm);
    int k;
    pushReq(a, b, op, '0);
    k = 0;
    @(negedge CLK);
    while (!OutValid && k < 20) begin
      @(negedge CLK);
      k++;
      if (k == 1) check({nm, "Operand1"}, FpuOperand1, a);
    end
    check({nm, "Latency"}, k, 8);
    check({nm, "Result"}, OutResult, exp);
    @(negedge CLK);
    check({nm, "BusyAfterPop"}, Busy, 0);
    sync();
  endtask

  initial begin
    InValid = 0;
    InOperand1 = '0;
    InOperand2 = '0;
    InOperation = '0;
    InTag = '0;
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("resetInReady", InReady, 1);
    check("resetOutValid", OutValid, 0);
    check("resetBusy", Busy, 0);
    check("resetOperand", FpuOperand1, 32'h0);
    check("modelSub", fpuCalc(32'h40400000, 32'h3F800000, 2'b01), 32'h40000000);
    check("modelDiv", fpuCalc(32'h41000000, 32'h40000000, 2'b11), 32'h40800000);
    sync();

    singleOp(32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, "add");
    singleOp(32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, "mul");

    popCnt = 0;
    for (int i = 0; i < 16; i++) pushReq(vals[i%8], vals[(i+3)%8], 2'b00, '0);
    waitIdle(100, "streamDrain");
    check("streamCount", popCnt, 16);

    sync();
    fixedReady = 0;
    for (int i = 0; i < 12; i++) pushReq(vals[i%8], vals[(i*5)%8], 2'(i), '0);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check("bpInReady", InReady, 0);
    check("bpOutValid", OutValid, 1);
    check("bpOutCount", dut.outCount, 8);
    check("bpInflight", dut.inflight, 0);
    check("bpModelOut", outQ.size(), 8);
    check("bpModelIn", inQ.size(), 4);
    sync();
    popCnt = 0;
    fixedReady = 1;
    waitIdle(100, "bpDrain");
    check("bpPopCount", popCnt, 12);

    sync();
    fixedReady = 0;
    for (int i = 0; i < 5; i++) pushReq(vals[i], vals[7-i], 2'b10, '0);
    repeat (5) @(posedge CLK);
    #1;
    check("preRstOutCount", dut.outCount, 2);
    check("preRstInflight", dut.inflight, 3);
    RST = 1'b1;
    #1;
    check("midRstOutValid", OutValid, 0);
    check("midRstInReady", InReady, 1);
    check("midRstBusy", Busy, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    fixedReady = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("postRstQuiet", OutValid, 0);
    end
    sync();
    singleOp(32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, "postRstAdd");

`ifdef FPU_ISSUE_TAG_EN
    randReady = 1;
    tagRec = 1;
    tagLog.delete();
    for (int t = 0; t < 16; t++) pushReq(vals[t%8], vals[(t+1)%8], 2'(t), TAG_W'(t));
    waitIdle(400, "tagDrain");
    tagRec = 0;
    check("tagCount", tagLog.size(), 16);
    for (int t = 0; t < 16 && t < tagLog.size(); t++) check("tagOrder", tagLog[t], t);
    sync();
`endif

    randReady = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) sync();
      else pushReq(vals[$urandom_range(0, 7)], vals[$urandom_range(0, 7)],
                   2'($urandom_range(0, 3)), TAG_W'($urandom));
    end
    waitIdle(400, "randDrain");
    randReady = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
